hash_arbiter: RTL and testbench

Round-robin controller that shares the single `hash` datapath unit among `NUM_REQ` requesters. It accepts key requests, sequences the hash unit's start/ready handshake including its release phase, and returns each 32-bit result with a one-cycle done pulse to the owning requester. It sits between the lookup-stage clients and the `hash` instance and is the only driver of that instance's `start_i`/`key_i`.

---
 rtl/hash_arbiter.sv | 130 +++++++++++++
 tb/tb_hash_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_arbiter.sv
// rtl/hash_arbiter.sv - round-robin sharing of one hash unit among NUM_REQ requesters.
// Optional WAIT timeout with err_o is built when HASH_ARB_TIMEOUT_EN is defined.
module hash_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*64-1:0]  key_i,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [31:0]            val_o,
    output logic [ID_W-1:0]        grant_id_o,
    output logic                   busy_o,
    output logic                   hash_start_o,
    output logic [63:0]            hash_key_o,
    input  logic                   hash_ready_i,
    input  logic [31:0]            hash_val_i
`ifdef HASH_ARB_TIMEOUT_EN
    ,
    output logic                   err_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [ID_W-1:0]    last;
    logic [NUM_REQ-1:0] arb_mask;
    logic               arb_found;
    logic [ID_W-1:0]    arb_idx;

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0]   wait_cnt;
`endif

    // The just-served requester sits out the RESP cycle so it can drop req_i.
    always_comb begin
        arb_mask = req_i;
        if (state == S_RESP)
            arb_mask = req_i & ~(NUM_REQ'(1) << grant_id_o);
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!arb_found && arb_mask[(int'(last) + i) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'((int'(last) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            last         <= ID_W'(NUM_REQ - 1);
            done_o       <= '0;
            val_o        <= '0;
            grant_id_o   <= '0;
            busy_o       <= 1'b0;
            hash_start_o <= 1'b0;
            hash_key_o   <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
            err_o        <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            done_o <= '0;
`ifdef HASH_ARB_TIMEOUT_EN
            err_o  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        last         <= arb_idx;
                        grant_id_o   <= arb_idx;
                        hash_key_o   <= key_i[int'(arb_idx)*64 +: 64];
                        state        <= S_ISSUE;
                        busy_o       <= 1'b1;
                        hash_start_o <= 1'b1;
                    end
                end
                // Ready may still be high from the previous operation here.
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef HASH_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (hash_ready_i) begin
                        val_o        <= hash_val_i;
                        done_o       <= NUM_REQ'(1) << grant_id_o;
                        state        <= S_RESP;
                        hash_start_o <= 1'b0;
                    end
`ifdef HASH_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        val_o        <= '0;
                        done_o       <= NUM_REQ'(1) << grant_id_o;
                        err_o        <= 1'b1;
                        state        <= S_RESP;
                        hash_start_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (arb_found) begin
                        last         <= arb_idx;
                        grant_id_o   <= arb_idx;
                        hash_key_o   <= key_i[int'(arb_idx)*64 +: 64];
                        state        <= S_ISSUE;
                        hash_start_o <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_arbiter.sv
// tb/tb_hash_arbiter.sv - directed bench for hash_arbiter with a behavioural hash unit.
module tb_hash_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*64-1:0] key_bus;
    logic [NUM_REQ-1:0]    done_o;
    logic [31:0]           val_o;
    logic [ID_W-1:0]       grant_id_o;
    logic                  busy_o;
    logic                  hash_start_o;
    logic [63:0]           hash_key_o;
    logic                  hash_ready;
    logic [31:0]           hash_val;
`ifdef HASH_ARB_TIMEOUT_EN
    logic                  err_o;
`endif

    int total = 0;
    int bad   = 0;
    logic stall;

    always #5 clk = ~clk;

    hash_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .key_i        (key_bus),
        .done_o       (done_o),
        .val_o        (val_o),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o),
        .hash_start_o (hash_start_o),
        .hash_key_o   (hash_key_o),
        .hash_ready_i (hash_ready),
        .hash_val_i   (hash_val)
`ifdef HASH_ARB_TIMEOUT_EN
        ,
        .err_o        (err_o)
`endif
    );

    // Stand-in hash unit: FREE -> BUSY -> DONE, leaves DONE once start drops.
    function automatic logic [31:0] hfunc(input logic [63:0] k);
        if (k == 64'h0101010101010101) return 32'h00000008;
        if (k == 64'hFFFFFFFFFFFFFFFF) return 32'h000000FF;
        return k[63:32] ^ k[31:0];
    endfunction

    logic [1:0] hst;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hst      <= 2'd0;
            hash_val <= '0;
        end else begin
            case (hst)
                2'd0: if (hash_start_o) hst <= 2'd1;
                2'd1: if (!stall) begin hst <= 2'd2; hash_val <= hfunc(hash_key_o); end
                default: if (!hash_start_o) hst <= 2'd0;
            endcase
        end
    end
    assign hash_ready = (hst == 2'd2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_key(input int n, input logic [63:0] k);
        key_bus[n*64 +: 64] = k;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end while (done_o == '0 && cnt < 40);
    endtask

    logic [3:0]  rr_done [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] rr_val  [5] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hA0000001};

    initial begin
        int n;
        int extra;
        rst = 1'b1; req = '0; key_bus = '0; stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_done",  done_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_start", hash_start_o, 0);
        check("rst_val",   val_o, 0);
        check("rst_key",   hash_key_o, 0);
        check("rst_grant", grant_id_o, 0);

        // single request, requester 0
        set_key(0, 64'h0101010101010101);
        req = 4'b0001;
        @(posedge clk); @(negedge clk);
        check("t1_busy_issue", busy_o, 1);
        check("t1_start_issue", hash_start_o, 1);
        wait_done(n);
        check("t1_lat",   n + 1, 4);
        check("t1_done",  done_o, 4'b0001);
        check("t1_val",   val_o, 32'h8);
        check("t1_grant", grant_id_o, 0);
        check("t1_start_resp", hash_start_o, 0);
        req = '0;
        @(negedge clk);
        check("t1_pulse", done_o, 0);
        check("t1_idle",  busy_o, 0);
        check("t1_hold",  val_o, 32'h8);

        // requester 2, all-ones key
        set_key(2, 64'hFFFFFFFFFFFFFFFF);
        req = 4'b0100;
        wait_done(n);
        check("t2_lat",   n, 4);
        check("t2_done",  done_o, 4'b0100);
        check("t2_val",   val_o, 32'hFF);
        check("t2_grant", grant_id_o, 2);
        req = '0;
        @(negedge clk);

        // full 32-bit result passes through
        set_key(1, 64'hDEADBEEF_00000000);
        req = 4'b0010;
        wait_done(n);
        check("t3_done", done_o, 4'b0010);
        check("t3_val",  val_o, 32'hDEADBEEF);
        req = '0;
        @(negedge clk);

        // round robin with all four requesting, from a fresh reset
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        set_key(0, 64'hA0000001_00000000);
        set_key(1, 64'hB0000002_00000000);
        set_key(2, 64'hC0000003_00000000);
        set_key(3, 64'hD0000004_00000000);
        req = 4'b1111;
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done(n);
            check("t4_gap",   n + extra, 4);
            check("t4_done",  done_o, rr_done[k]);
            check("t4_val",   val_o, rr_val[k]);
            check("t4_start_resp", hash_start_o, 0);
            if (k == 4) req = '0;
            @(negedge clk);
            if (k < 4) check("t4_start_issue", hash_start_o, 1);
            extra = 1;
        end

        // requester 1 re-requests during its own RESP while 3 is pending
        set_key(1, 64'h11110000_00000000);
        set_key(3, 64'h33330000_00000000);
        req = 4'b1010;
        wait_done(n);
        check("t5_done_a", done_o, 4'b0010);
        check("t5_val_a",  val_o, 32'h11110000);
        set_key(1, 64'h12345678_00000000);
        req = 4'b1010;
        wait_done(n);
        check("t5_lat_b",  n, 4);
        check("t5_done_b", done_o, 4'b1000);
        check("t5_val_b",  val_o, 32'h33330000);
        check("t5_grant_b", grant_id_o, 3);
        req = 4'b0010;
        wait_done(n);
        check("t5_lat_c",  n, 4);
        check("t5_done_c", done_o, 4'b0010);
        check("t5_val_c",  val_o, 32'h12345678);
        req = '0;
        @(negedge clk);

        // reset in WAIT aborts; pending request served after release
        set_key(2, 64'h55550000_00000000);
        req = 4'b0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_wait_start", hash_start_o, 1);
        rst = 1'b1;
        #1;
        check("t6_busy",  busy_o, 0);
        check("t6_start", hash_start_o, 0);
        check("t6_done",  done_o, 0);
        check("t6_val",   val_o, 0);
        check("t6_grant", grant_id_o, 0);
        check("t6_key",   hash_key_o, 0);
        repeat (2) @(negedge clk);
        check("t6_no_done", done_o, 0);
        rst = 1'b0;
        wait_done(n);
        check("t6_lat",  n, 4);
        check("t6_done_after", done_o, 4'b0100);
        check("t6_val_after",  val_o, 32'h55550000);
        req = '0;
        @(negedge clk);

`ifdef HASH_ARB_TIMEOUT_EN
        stall = 1'b1;
        set_key(0, 64'h77770000_00000000);
        req = 4'b0001;
        wait_done(n);
        check("t7_lat",  n, TIMEOUT + 2);
        check("t7_done", done_o, 4'b0001);
        check("t7_err",  err_o, 1);
        check("t7_val",  val_o, 0);
        req = '0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        set_key(3, 64'h99990000_00000000);
        req = 4'b1000;
        wait_done(n);
        check("t7_done_next", done_o, 4'b1000);
        check("t7_val_next",  val_o, 32'h99990000);
        check("t7_err_next",  err_o, 0);
        req = '0;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
